// File: rtl/tx_msg_loader_if.sv
// Signal bundle between tx_msg_loader and its surroundings: the outgoing message stream,
// the endpoint peripheral bus and the per-message status pulses.
interface tx_msg_loader_if #(
  parameter int unsigned NUM_MSGS = 4
) ();
  localparam int unsigned SlotW = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1;

  // Message stream
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_data;
  logic                in_last;
  logic [NUM_MSGS-1:0] slot_busy;

  // Peripheral bus
  logic [31:0]         bus_addr;
  logic                bus_wen;
  logic                bus_ren;
  logic [31:0]         bus_wdata;
  logic [3:0]          bus_strobe;
  logic [31:0]         bus_rdata;
  logic                bus_error;
  logic                bus_request_stall;

  // Status
  logic                msg_done;
  logic                msg_err;
  logic [SlotW-1:0]    cur_slot;

  // Loader side
  modport master (
    input  in_valid, in_data, in_last, slot_busy,
    input  bus_rdata, bus_error, bus_request_stall,
    output in_ready,
    output bus_addr, bus_wen, bus_ren, bus_wdata, bus_strobe,
    output msg_done, msg_err, cur_slot
  );

  // Stream source / endpoint side
  modport slave (
    output in_valid, in_data, in_last, slot_busy,
    output bus_rdata, bus_error, bus_request_stall,
    input  in_ready,
    input  bus_addr, bus_wen, bus_ren, bus_wdata, bus_strobe,
    input  msg_done, msg_err, cur_slot
  );
endinterface

// File: rtl/tx_msg_loader.sv
// Streams an outgoing message into a round-robin TX cache slot, then programs the slot's
// packet start pointer and writes the slot index to the endpoint's send register.
module tx_msg_loader #(
  parameter int unsigned NUM_MSGS            = 4,
  parameter int unsigned SLOT_WORDS          = 32,
  parameter logic [31:0] TX_SEND_ADDR        = 32'h1004,
  parameter logic [31:0] TX_CACHE_START_ADDR = 32'h2000
) (
  input  logic            clk,
  input  logic            n_rst,
  tx_msg_loader_if.master bus
);

  localparam int unsigned SlotW     = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1;
  localparam int unsigned CntW      = $clog2(SLOT_WORDS + 1);
  localparam logic [31:0] SlotWords = 32'(SLOT_WORDS);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StPtr,
    StTrig,
    StDrain
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CntW-1:0]  r_cnt;
  logic [CntW-1:0]  w_cnt_nxt;
  logic [SlotW-1:0] r_cur_slot;
  logic [SlotW-1:0] w_slot_nxt;
  logic             r_msg_done;
  logic             w_done_nxt;
  logic             r_msg_err;
  logic             w_err_nxt;

  logic             w_wen;
  logic             w_ready;
  logic [31:0]      w_addr;
  logic [31:0]      w_wdata;

  logic [31:0]      w_slot_word;
  logic [31:0]      w_load_addr;
  logic             w_accept;
  logic             w_complete;
  logic             w_unused_rdata;

  // First cache word of the current slot, in words.
  assign w_slot_word = 32'(r_cur_slot) * SlotWords;
  assign w_load_addr = TX_CACHE_START_ADDR + ((w_slot_word + 32'(r_cnt)) << 2);

  // In LOAD a word is accepted exactly when its bus write completes.
  assign w_accept   = bus.in_valid & ~bus.bus_request_stall;
  assign w_complete = ~bus.bus_request_stall;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_slot_nxt  = r_cur_slot;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_wen       = 1'b0;
    w_ready     = 1'b0;
    w_addr      = '0;
    w_wdata     = '0;

    unique case (r_state)
      StIdle: begin
        if (bus.in_valid && !bus.slot_busy[r_cur_slot]) begin
          w_state_nxt = StLoad;
        end
      end

      StLoad: begin
        w_wen   = bus.in_valid;
        w_addr  = w_load_addr;
        w_wdata = bus.in_data;
        w_ready = ~bus.bus_request_stall;
        if (w_accept) begin
          w_cnt_nxt = r_cnt + CntW'(1);
          if (bus.bus_error) begin
            w_err_nxt = 1'b1;
            // A failed final word leaves nothing to drain.
            if (bus.in_last) begin
              w_cnt_nxt   = '0;
              w_state_nxt = StIdle;
            end else begin
              w_state_nxt = StDrain;
            end
          end else if (bus.in_last) begin
            w_state_nxt = StPtr;
          end else if (r_cnt == CntW'(SLOT_WORDS - 1)) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = StDrain;
          end
        end
      end

      StPtr: begin
        w_wen   = 1'b1;
        w_addr  = 32'(r_cur_slot) << 2;
        w_wdata = w_slot_word << 2;
        if (w_complete) begin
          if (bus.bus_error) begin
            w_err_nxt   = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = StIdle;
          end else begin
            w_state_nxt = StTrig;
          end
        end
      end

      StTrig: begin
        w_wen   = 1'b1;
        w_addr  = TX_SEND_ADDR;
        w_wdata = 32'(r_cur_slot);
        if (w_complete) begin
          w_cnt_nxt   = '0;
          w_state_nxt = StIdle;
          if (bus.bus_error) begin
            w_err_nxt = 1'b1;
          end else begin
            w_done_nxt = 1'b1;
            w_slot_nxt = (r_cur_slot == SlotW'(NUM_MSGS - 1)) ? '0 : r_cur_slot + SlotW'(1);
          end
        end
      end

      StDrain: begin
        w_ready = 1'b1;
        if (bus.in_valid && bus.in_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = StIdle;
        end
      end

      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_cur_slot <= '0;
      r_msg_done <= 1'b0;
      r_msg_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_cur_slot <= w_slot_nxt;
      r_msg_done <= w_done_nxt;
      r_msg_err  <= w_err_nxt;
    end
  end

  // Reset silences the bus and the stream immediately, even mid-message.
  assign bus.bus_wen    = w_wen & ~n_rst;
  assign bus.in_ready   = w_ready & ~n_rst;
  assign bus.bus_addr   = n_rst ? '0 : w_addr;
  assign bus.bus_wdata  = n_rst ? '0 : w_wdata;
  assign bus.bus_ren    = 1'b0;
  assign bus.bus_strobe = 4'hF;
  assign bus.msg_done   = r_msg_done;
  assign bus.msg_err    = r_msg_err;
  assign bus.cur_slot   = r_cur_slot;

  assign w_unused_rdata = ^bus.bus_rdata;

  done_err_exclusive_a : assert property (@(posedge clk) disable iff (n_rst)
    !(r_msg_done && r_msg_err));

endmodule
